// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FSM encodings and fp64 field constants for the add/sub scheduler
package fpu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int FP64_W      = 64;
  localparam int FP64_EXP_W  = 11;
  localparam int FP64_FRAC_W = 52;

  // Inf/NaN operand: exponent field all-ones
  function automatic logic is_special(input logic [FP64_W-1:0] x);
    return &x[FP64_W-2 -: FP64_EXP_W];
  endfunction

endpackage

// File: rtl/addition_subtraction.sv
// rtl/addition_subtraction.sv - shared combinational fp64 add/sub datapath (truncating)
module Addition_Subtraction
  import fpu_pkg::*;
(
  input  logic [FP64_W-1:0] a_operand,
  input  logic [FP64_W-1:0] b_operand,
  input  logic              AddBar_Sub,
  input  logic              en,
  output logic              Exception,
  output logic [FP64_W-1:0] Result
);

  // hidden bit + fraction + 3 guard bits
  localparam int MW = FP64_FRAC_W + 4;

  logic [FP64_EXP_W-1:0] ea_raw, eb_raw, ea, eb, ex, ey, d, er;
  logic [MW-1:0]         ma, mb, mx, my, my_sh, mn;
  logic [MW:0]           sum;
  logic                  sa, sb, sx, sy, swap;
  logic [5:0]            msb, lz;

  assign ea_raw = a_operand[FP64_W-2 -: FP64_EXP_W];
  assign eb_raw = b_operand[FP64_W-2 -: FP64_EXP_W];

  always_comb begin
    ea   = (ea_raw == '0) ? FP64_EXP_W'(1) : ea_raw;
    eb   = (eb_raw == '0) ? FP64_EXP_W'(1) : eb_raw;
    ma   = {|ea_raw, a_operand[FP64_FRAC_W-1:0], 3'b000};
    mb   = {|eb_raw, b_operand[FP64_FRAC_W-1:0], 3'b000};
    sa   = a_operand[FP64_W-1];
    sb   = b_operand[FP64_W-1] ^ AddBar_Sub;
    swap = {ea, ma} < {eb, mb};
    ex   = swap ? eb : ea;
    ey   = swap ? ea : eb;
    mx   = swap ? mb : ma;
    my   = swap ? ma : mb;
    sx   = swap ? sb : sa;
    sy   = swap ? sa : sb;
    d    = ex - ey;
    my_sh = (d >= FP64_EXP_W'(MW)) ? '0 : (my >> d);
    sum  = (sx == sy) ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});

    msb = '0;
    for (int i = 0; i < MW; i++) begin
      if (sum[i]) msb = 6'(i);
    end
    lz = 6'(MW - 1) - msb;

    mn = '0;
    er = '0;
    if (sum[MW]) begin
      mn = sum[MW:1];
      er = ex + 1'b1;
    end else if (sum[MW-1:0] == '0) begin
      mn = '0;
      er = '0;
    end else if (ex > FP64_EXP_W'(lz)) begin
      mn = sum[MW-1:0] << lz;
      er = ex - FP64_EXP_W'(lz);
    end else begin
      mn = sum[MW-1:0] << (ex - 1'b1);
      er = '0;
    end

    Exception = en & (is_special(a_operand) | is_special(b_operand));
    if (!en || Exception)
      Result = '0;
    else if (er == '1)
      Result = {sx, {FP64_EXP_W{1'b1}}, {FP64_FRAC_W{1'b0}}};
    else
      Result = {sx, er, mn[MW-2:3]};
  end

endmodule

// File: rtl/fpu_addsub_scheduler_rr_arbiter.sv
// rtl/fpu_addsub_scheduler_rr_arbiter.sv - combinational round-robin pick starting after ptr
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_scheduler.sv
// rtl/fpu_addsub_scheduler.sv - round-robin sharing of one fp64 add/sub datapath
// IDLE grants and registers operands, EXEC captures the datapath, RESP waits for rsp_ready.
module fpu_addsub_scheduler
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [FP64_W*NUM_REQ-1:0] req_a,
  input  logic [FP64_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [FP64_W-1:0]         rsp_result,
  output logic                      rsp_exception,
  output logic                      busy,
  output logic [CNT_W-1:0]          exc_count
);

  logic [1:0]         state, next_state;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id, rr_ptr, op_id;
  logic [FP64_W-1:0]  op_a, op_b, a_sel, b_sel, dp_result;
  logic               op_sub, op_sel, dp_exc, dp_en, accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel  = req_a[FP64_W*i +: FP64_W];
        b_sel  = req_b[FP64_W*i +: FP64_W];
        op_sel = req_op[i];
      end
    end
  end

  assign accept = (state == ST_IDLE) && (|gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_EXEC;
      ST_EXEC: next_state = ST_RESP;
      ST_RESP: if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // reset gates the grant so req_ready drops without waiting for a clock edge
  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    dp_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = reset ? '0 : gnt;
      end
      ST_EXEC: dp_en     = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  Addition_Subtraction u_addsub (
    .a_operand  (op_a),
    .b_operand  (op_b),
    .AddBar_Sub (op_sub),
    .en         (dp_en),
    .Exception  (dp_exc),
    .Result     (dp_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      op_a          <= '0;
      op_b          <= '0;
      op_sub        <= 1'b0;
      op_id         <= '0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_exception <= 1'b0;
      exc_count     <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= gnt_id;
        op_a   <= a_sel;
        op_b   <= b_sel;
        op_sub <= op_sel;
        op_id  <= gnt_id;
      end
      if (state == ST_EXEC) begin
        rsp_result    <= dp_result;
        rsp_exception <= dp_exc;
        rsp_id        <= op_id;
      end
      if (state == ST_RESP && rsp_ready && rsp_exception && exc_count != '1)
        exc_count <= exc_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_scheduler.sv
// tb/tb_fpu_addsub_scheduler.sv - scoreboard bench for the fp64 add/sub scheduler
module tb_fpu_addsub_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 3;

  localparam logic [63:0] F_1P0  = 64'h3FF0000000000000;
  localparam logic [63:0] F_1P5  = 64'h3FF8000000000000;
  localparam logic [63:0] F_2P0  = 64'h4000000000000000;
  localparam logic [63:0] F_3P0  = 64'h4008000000000000;
  localparam logic [63:0] F_M1P0 = 64'hBFF0000000000000;
  localparam logic [63:0] F_INF  = 64'h7FF0000000000000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [64*NUM_REQ-1:0] req_a = '0;
  logic [64*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]   req_op = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [ID_W-1:0]      rsp_id;
  logic [63:0]          rsp_result;
  logic                 rsp_exception;
  logic                 busy;
  logic [CNT_W-1:0]     exc_count;

  fpu_addsub_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_exception (rsp_exception),
    .busy          (busy),
    .exc_count     (exc_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     res;
    logic            exc;
  } rsp_t;

  rsp_t sb[$];
  int   g_id[$];
  int   g_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // monitor: logs grants and scores every response handshake
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (req_ready & req_valid) != '0) begin
        for (int i = 0; i < NUM_REQ; i++)
          if (req_ready[i] && req_valid[i]) begin
            g_id.push_back(i);
            g_cyc.push_back(cyc);
          end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got id %0d result %h, required no response", rsp_id, rsp_result);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_exception", 64'(rsp_exception), 64'(e.exc));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic op);
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
    req_op[i]         = op;
  endtask

  task automatic wait_accept(input int i);
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i] && req_valid[i]) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL accept_timeout: req %0d got no grant, required a grant", i);
    end
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL idle_timeout: busy stuck at 1, required 0");
    end
  endtask

  task automatic issue(input int i);
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    wait_accept(i);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    // reset: outputs idle even while requests are pending
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_rsp_result", rsp_result, 64'h0);
    chk("reset_rsp_id", 64'(rsp_id), 64'h0);
    chk("reset_exc_count", 64'(exc_count), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;

    // fairness: all four valid continuously
    set_req(0, F_1P0, F_2P0, 1'b0);
    set_req(1, F_2P0, F_1P0, 1'b1);
    set_req(2, F_1P5, F_1P5, 1'b0);
    set_req(3, F_1P0, F_2P0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{id: 2'd0, res: F_3P0,  exc: 1'b0});
      sb.push_back('{id: 2'd1, res: F_1P0,  exc: 1'b0});
      sb.push_back('{id: 2'd2, res: F_3P0,  exc: 1'b0});
      sb.push_back('{id: 2'd3, res: F_M1P0, exc: 1'b0});
    end
    g_id.delete();
    g_cyc.delete();
    @(posedge clk); #1;
    req_valid = 4'hF;
    for (int k = 0; k < 60 && g_id.size() < 8; k++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("fair_grant_count", 64'(g_id.size()), 64'd8);
    if (g_id.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("fair_grant_id", 64'(g_id[k]), 64'(k % 4));
        if (k > 0) chk("fair_grant_gap", 64'(g_cyc[k] - g_cyc[k-1]), 64'd3);
      end
    end
    wait_idle();

    // single request with exact latency
    set_req(2, F_1P0, F_2P0, 1'b0);
    sb.push_back('{id: 2'd2, res: F_3P0, exc: 1'b0});
    @(posedge clk); #1;
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("single_grant_T", 64'(req_ready), 64'h4);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("single_rsp_valid_T1", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    chk("single_rsp_valid_T2", 64'(rsp_valid), 64'h1);
    wait_idle();

    // backpressure: stalled consumer while req 1 waits
    rsp_ready = 1'b0;
    set_req(0, F_1P0, F_2P0, 1'b0);
    set_req(1, F_2P0, F_1P0, 1'b1);
    sb.push_back('{id: 2'd0, res: F_3P0, exc: 1'b0});
    sb.push_back('{id: 2'd1, res: F_1P0, exc: 1'b0});
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    wait_accept(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("bp_rsp_id", 64'(rsp_id), 64'h0);
      chk("bp_rsp_result", rsp_result, F_3P0);
      chk("bp_req_ready", 64'(req_ready), 64'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_no_grant", 64'(req_ready), 64'h0);
    @(negedge clk);
    chk("bp_grant_after", 64'(req_ready), 64'h2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle();

    // exception counting and saturation (CNT_W = 3)
    chk("exc_count_start", 64'(exc_count), 64'h0);
    set_req(3, F_INF, F_1P0, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      sb.push_back('{id: 2'd3, res: 64'h0, exc: 1'b1});
      issue(3);
      wait_idle();
      chk("exc_count", 64'(exc_count), 64'((n < 7) ? n : 7));
    end

    // reset during EXEC drops the op; next grant restarts at req 0
    set_req(1, F_1P0, F_2P0, 1'b0);
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    wait_accept(1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("midop_busy", 64'(busy), 64'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("midop_busy_rst", 64'(busy), 64'h0);
    chk("midop_rsp_valid_rst", 64'(rsp_valid), 64'h0);
    chk("midop_rsp_id_rst", 64'(rsp_id), 64'h0);
    chk("midop_rsp_exc_rst", 64'(rsp_exception), 64'h0);
    chk("midop_exc_count_rst", 64'(exc_count), 64'h0);
    chk("midop_req_ready_rst", 64'(req_ready), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    set_req(0, F_1P0, F_2P0, 1'b0);
    set_req(3, F_1P0, F_2P0, 1'b1);
    sb.push_back('{id: 2'd0, res: F_3P0,  exc: 1'b0});
    sb.push_back('{id: 2'd3, res: F_M1P0, exc: 1'b0});
    req_valid = 4'b1001;
    @(negedge clk);
    chk("post_reset_grant", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_accept(3);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
